dmem_port_arbiter: RTL
======================

# dmem_port_arbiter

Shares the single-port data memory between the processor's MM-stage access and a host port used for loading and inspection. Processor accesses always have priority, so the pipeline never stalls in normal operation. Host requests are served in idle memory cycles through a req/gnt handshake, and read data comes back one cycle later. An optional starvation guard forces a one-cycle processor hold so that a waiting host is guaranteed progress.

## Interface
Parameters:
- AW, 32: word-address width.
- DW, 32: data width.
- STARVE_LIMIT, 15: number of consecutive denied host cycles before a forced grant (guard build only), 1..255.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- cpu_addr  in  AW  processor word address (MM stage).
- cpu_wdata  in  DW  processor store data.
- cpu_we  in  1  processor store, already qualified by stage-valid.
- cpu_re  in  1  processor load, already qualified by stage-valid.
- cpu_rdata  out  DW  load data, valid in the cycle after cpu_re.
- cpu_hold  out  1  processor must not access memory this cycle.
- host_req  in  1  host access request; held until granted.
- host_we  in  1  host write (1) / read (0).
- host_addr  in  AW  host word address.
- host_wdata  in  DW  host write data.
- host_gnt  out  1  host access performed this cycle.
- host_rvalid  out  1  host read data valid.
- host_rdata  out  DW  host read data.
- host_wait_cnt  out  8  consecutive denied cycles, saturating at 255.
- mem_addr  out  AW  memory address.
- mem_in  out  DW  memory write data.
- mem_we  out  1  memory write enable.
- mem_out  in  DW  memory read data; synchronous, 1-cycle latency.

## Operation
- cpu_act = (cpu_re | cpu_we) & ~cpu_hold.
- host_gnt = host_req & ~cpu_act.
- Memory mux, combinational:
  - cpu_act: mem_addr=cpu_addr, mem_in=cpu_wdata, mem_we=cpu_we.
  - host_gnt: mem_addr=host_addr, mem_in=host_wdata, mem_we=host_we.
  - Otherwise mem_addr=0 and mem_we=0.
- cpu_re & cpu_we both set: treated as a store (mem_we=1); no error.
- cpu_rdata = mem_out (passthrough).
- host_rdata = host_rvalid ? mem_out : 0.
- host_rvalid register is set to host_gnt & ~host_we.
- host_wait_cnt: cleared on host_gnt or when host_req=0; increments when host_req & ~host_gnt; saturates at 255.
- Guard FSM (guard build only):
  - NORM: go to HOLD when host_req & ~host_gnt & host_wait_cnt == STARVE_LIMIT-1.
  - HOLD: cpu_hold=1 for exactly one cycle. host_gnt is then 1 whenever host_req=1. Return to NORM unconditionally.
  - Host dropping host_req while in HOLD: no grant; FSM still returns to NORM.
- The processor honours cpu_hold by freezing the MM stage for that cycle; the arbiter does not buffer processor requests.

## Timing
- Reset values: cpu_hold=0, host_gnt=0 (combinational, follows inputs), host_rvalid=0, host_rdata=0, host_wait_cnt=0, FSM=NORM, mem_we=0 unless cpu_we.
- Reset asserted mid-operation: a pending host_rvalid is dropped, the counter is cleared, and the FSM returns to NORM in the same edge.
- Grant is zero-latency: host_gnt is in the same cycle as the winning host_req.
- Host read: host_rvalid is exactly 1 cycle after host_gnt.
- Back-to-back host grants give back-to-back rvalid.
- Host write: completes on the grant edge; no response.
- Processor load: data in the cycle after cpu_re. Unaffected by a host grant in the preceding cycle, since that cycle had no processor access.
- Forced grant: cpu_hold is asserted in the cycle after host_wait_cnt reaches STARVE_LIMIT-1 with the host still denied.

## Configuration
- DMEM_ARB_STARVE_GUARD_EN defined: guard FSM present and cpu_hold is driven as specified.
- DMEM_ARB_STARVE_GUARD_EN undefined: FSM removed, cpu_hold tied 0 and the host can starve indefinitely. host_wait_cnt remains functional.

## Test plan
- Idle processor; host reads addr 0x10 holding 0xDEADBEEF -> host_gnt the same cycle; host_rvalid=1 and host_rdata=0xDEADBEEF the next cycle.
- Processor store 0x5 to addr 3 while host_req is also active -> mem_we=1 and mem_addr=3 from the processor; host_gnt=0 and host_wait_cnt=1. Host is granted in the first processor-idle cycle.
- Alternating processor load and host read, 8 cycles -> cpu_rdata and host_rdata each match memory contents; no rvalid is misattributed.
- Guard build, STARVE_LIMIT=4, processor accessing every cycle, host_req held -> cpu_hold=1 for one cycle after 4 denied cycles; host granted in that cycle; counter returns to 0.
- Non-guard build, same stimulus for 300 cycles -> cpu_hold never asserted; host_wait_cnt saturates at 255.
- Assert rst in the cycle between a host read grant and its rvalid -> host_rvalid=0, host_rdata=0, host_wait_cnt=0 in the next cycle.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the data memory between the MM-stage access (priority) and a host port.
// Define DMEM_ARB_STARVE_GUARD_EN to enable the starvation guard that forces a one-cycle processor hold.
module dmem_port_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int STARVE_LIMIT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_we,
    input  logic          cpu_re,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_hold,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_gnt,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,
    output logic [7:0]    host_wait_cnt,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_in,
    output logic          mem_we,
    input  logic [DW-1:0] mem_out
);
    localparam logic [7:0] LIM = 8'(STARVE_LIMIT - 1);
    logic cpu_act;
    assign cpu_act = (cpu_re | cpu_we) & ~cpu_hold;
    assign host_gnt = host_req & ~cpu_act;
    assign mem_addr = cpu_act ? cpu_addr : host_gnt ? host_addr : '0;
    assign mem_in = cpu_act ? cpu_wdata : host_gnt ? host_wdata : '0;
    assign mem_we = cpu_act ? cpu_we : host_gnt & host_we;
    assign cpu_rdata = mem_out;
    assign host_rdata = host_rvalid ? mem_out : '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            host_rvalid <= 1'b0;
            host_wait_cnt <= 8'd0;
        end else begin
            host_rvalid <= host_gnt & ~host_we;
            host_wait_cnt <= (host_gnt | ~host_req) ? 8'd0 :
                             (host_wait_cnt == 8'hFF) ? host_wait_cnt : host_wait_cnt + 8'd1;
        end
    end
`ifdef DMEM_ARB_STARVE_GUARD_EN
    localparam logic [0:0] NORM = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;
    logic [0:0] state;
    always_ff @(posedge clk) begin
        if (rst)
            state <= NORM;
        else
            state <= (state == HOLD) ? NORM :
                     (host_req & ~host_gnt & (host_wait_cnt == LIM)) ? HOLD : NORM;
    end
    assign cpu_hold = (state == HOLD);
`else
    logic unused_limit;
    assign unused_limit = ^LIM;
    assign cpu_hold = 1'b0;
`endif
endmodule
